// File: rtl/generic_sram_byte_en_arb.sv
// Multi-client SRAM with byte-lane write enables, round-robin arbitration
// and a registered, one-cycle read-return path with a per-client valid.
// Optional feature macro: GENERIC_SRAM_BYTE_EN_ARB_PARITY_EN
//   defined   -> one even-parity bit per byte lane is stored and checked on read
//   undefined -> no parity storage, parity_err is tied low
module generic_sram_byte_en_arb #(
  parameter int unsigned NUM_ADDR_BITS = 10,
  parameter int unsigned NUM_DATA_BITS = 32,
  parameter int unsigned N_CLIENTS     = 2
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [N_CLIENTS*NUM_ADDR_BITS-1:0]     addr,
  input  logic [N_CLIENTS*NUM_DATA_BITS-1:0]     write_data,
  input  logic [N_CLIENTS*(NUM_DATA_BITS/8)-1:0] byte_en,
  input  logic [N_CLIENTS-1:0]                   write_en,
  input  logic [N_CLIENTS-1:0]                   read_en,
  output logic [N_CLIENTS-1:0]                   gnt,
  output logic [NUM_DATA_BITS-1:0]               read_data,
  output logic [N_CLIENTS-1:0]                   read_valid,
  output logic [N_CLIENTS-1:0]                   parity_err
);

  localparam int unsigned NB    = NUM_DATA_BITS / 8;
  localparam int unsigned DEPTH = 2 ** NUM_ADDR_BITS;
  localparam int unsigned RR_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  // Elaboration-time parameter sanity checks
  generate
    if ((NUM_DATA_BITS % 8) != 0 || NUM_DATA_BITS == 0) begin : g_bad_data_bits
      $error("NUM_DATA_BITS must be a non-zero multiple of 8");
    end
    if (N_CLIENTS < 1 || N_CLIENTS > 8) begin : g_bad_clients
      $error("N_CLIENTS must be in 1..8");
    end
  endgenerate

  logic [NUM_DATA_BITS-1:0] mem [DEPTH];

  logic [N_CLIENTS-1:0]     req;
  logic [N_CLIENTS-1:0]     rot_req;
  logic [N_CLIENTS-1:0]     gnt_c;
  logic                     any_gnt;
  logic                     found;
  int unsigned              pos;
  int unsigned              win;
  logic [RR_W-1:0]          rr;
  logic [RR_W-1:0]          gnt_idx;
  logic [NUM_ADDR_BITS-1:0] sel_addr;
  logic [NUM_DATA_BITS-1:0] sel_wdata;
  logic [NB-1:0]            sel_be;
  logic                     sel_we;
  logic                     sel_re;

  assign req     = write_en | read_en;
  assign any_gnt = |gnt_c;
  assign gnt     = gnt_c;

  // Round-robin pick: rotate requests so rr sits at bit 0, take the first set bit
  always_comb begin
    rot_req = N_CLIENTS'({req, req} >> rr);
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (!found && rot_req[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    win   = (32'(rr) + pos) % N_CLIENTS;
    gnt_c = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      gnt_c[i] = rstn && found && (i == win);
    end
  end

  // Route the granted client's request fields to the array
  always_comb begin
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    sel_re    = 1'b0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (gnt_c[i]) begin
        gnt_idx   = RR_W'(i);
        sel_addr  = addr[i*NUM_ADDR_BITS +: NUM_ADDR_BITS];
        sel_wdata = write_data[i*NUM_DATA_BITS +: NUM_DATA_BITS];
        sel_be    = byte_en[i*NB +: NB];
        sel_we    = write_en[i];
        sel_re    = read_en[i];
      end
    end
  end

  // Round-robin pointer advances past the winner, holds when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr <= '0;
    end else if (any_gnt) begin
      rr <= (gnt_idx == RR_W'(N_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Byte-masked array write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (any_gnt && sel_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (sel_be[b]) begin
          mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read return; old word is captured when read and write share an edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      read_data  <= '0;
      read_valid <= '0;
    end else begin
      read_valid <= '0;
      if (any_gnt && sel_re) begin
        read_data  <= mem[sel_addr];
        read_valid <= gnt_c;
      end
    end
  end

`ifdef GENERIC_SRAM_BYTE_EN_ARB_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic          par_bad_c;

  function automatic logic [NB-1:0] lane_parity(input logic [NUM_DATA_BITS-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      p[b] = ^w[b*8 +: 8];
    end
    return p;
  endfunction

  assign par_bad_c = |(par_mem[sel_addr] ^ lane_parity(mem[sel_addr]));

  // Parity bits are written alongside their lanes
  always_ff @(posedge clk) begin
    if (any_gnt && sel_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (sel_be[b]) begin
          par_mem[sel_addr][b] <= ^sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Parity error flag pulses together with read_valid of the reading client
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_err <= '0;
    end else begin
      parity_err <= '0;
      if (any_gnt && sel_re && par_bad_c) begin
        parity_err <= gnt_c;
      end
    end
  end
`else
  assign parity_err = '0;
`endif

endmodule

// File: tb/tb_generic_sram_byte_en_arb.sv
// Bench for generic_sram_byte_en_arb: directed scenarios pinned with literal
// values plus a randomized multi-client phase checked against a word-level model.
module tb_generic_sram_byte_en_arb;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int NB = DW / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   write_data;
  logic [N*NB-1:0]   byte_en;
  logic [N-1:0]      write_en;
  logic [N-1:0]      read_en;
  logic [N-1:0]      gnt;
  logic [DW-1:0]     read_data;
  logic [N-1:0]      read_valid;
  logic [N-1:0]      parity_err;

  always #5 clk = ~clk;

  generic_sram_byte_en_arb #(
    .NUM_ADDR_BITS(AW),
    .NUM_DATA_BITS(DW),
    .N_CLIENTS(N)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .addr(addr),
    .write_data(write_data),
    .byte_en(byte_en),
    .write_en(write_en),
    .read_en(read_en),
    .gnt(gnt),
    .read_data(read_data),
    .read_valid(read_valid),
    .parity_err(parity_err)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: memory as a sparse word map, arbiter pointer, last returned word
  logic [DW-1:0] mm [int];
  int            rr_m;
  logic [DW-1:0] rd_m;
  logic [N-1:0]  last_gnt;

  // Pending client requests (held until granted)
  bit            p_act [N];
  bit            p_we  [N];
  bit            p_re  [N];
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_d   [N];
  logic [NB-1:0] p_be  [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]       = p_addr[i];
      write_data[i*DW +: DW] = p_d[i];
      byte_en[i*NB +: NB]    = p_be[i];
      write_en[i]            = p_act[i] && p_we[i];
      read_en[i]             = p_act[i] && p_re[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      p_act[i] = 1'b0; p_we[i] = 1'b0; p_re[i] = 1'b0;
      p_addr[i] = '0; p_d[i] = '0; p_be[i] = '0;
    end
    drive();
  endtask

  task automatic set_req(input int c, input bit we, input bit re, input int a,
                         input logic [DW-1:0] d, input logic [NB-1:0] be);
    p_act[c] = 1'b1; p_we[c] = we; p_re[c] = re;
    p_addr[c] = AW'(a); p_d[c] = d; p_be[c] = be;
  endtask

  // One clock: called just after a posedge; predicts and checks grant, then the return
  task automatic step(output int g);
    logic [N-1:0]  ev;
    logic [DW-1:0] w;
    int            a;
    int            idx;
    drive();
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr_m + k) % N;
      if (g < 0 && p_act[idx]) g = idx;
    end
    last_gnt = gnt;
    chk("gnt", gnt, (g >= 0) ? (1 << g) : 0);
    ev = '0;
    if (g >= 0) begin
      a = int'(p_addr[g]);
      w = mm.exists(a) ? mm[a] : 'x;
      if (p_re[g]) begin
        ev[g] = 1'b1;
        rd_m  = w;
      end
      if (p_we[g]) begin
        for (int b = 0; b < NB; b++)
          if (p_be[g][b]) w[b*8 +: 8] = p_d[g][b*8 +: 8];
        mm[a] = w;
      end
      rr_m = (g + 1) % N;
      p_act[g] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("read_valid", read_valid, ev);
    if (!$isunknown(rd_m)) chk("read_data", read_data, rd_m);
    chk("parity_err", parity_err, 0);
  endtask

  task automatic access(input int c, input bit we, input bit re, input int a,
                        input logic [DW-1:0] d, input logic [NB-1:0] be);
    int g;
    int n;
    n = 0;
    set_req(c, we, re, a, d, be);
    do begin
      step(g);
      n++;
    end while (g != c && n < 20);
    if (g != c) begin
      checks++;
      failures++;
      $display("FAIL access_timeout client=%0d actual=no_grant required=grant", c);
      p_act[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_reqs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rr_m = 0;
    rd_m = '0;
    @(posedge clk);
    #1;
  endtask

  int g;
  int picks[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 1023};

  initial begin
    rstn = 1'b0;
    clear_reqs();
    rr_m = 0;
    rd_m = '0;
    // 1. reset with a pending read: everything quiet
    set_req(0, 1'b0, 1'b1, 'h010, '0, '0);
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_parity_err", parity_err, 0);
    clear_reqs();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 2. single client write then read
    access(0, 1'b1, 1'b0, 'h010, 32'hDEADBEEF, 4'hF);
    access(0, 1'b0, 1'b1, 'h010, '0, '0);
    chk("t2_valid", read_valid, 2'b01);
    chk("t2_data", read_data, 32'hDEADBEEF);

    // 3. byte mask, and an all-zero mask leaves the word intact
    access(1, 1'b1, 1'b0, 'h020, 32'h11223344, 4'hF);
    access(1, 1'b1, 1'b0, 'h020, 32'hAABBCCDD, 4'b0101);
    access(0, 1'b0, 1'b1, 'h020, '0, '0);
    chk("t3_mask", read_data, 32'h11BB33DD);
    access(1, 1'b1, 1'b0, 'h020, 32'hFFFFFFFF, 4'h0);
    access(1, 1'b0, 1'b1, 'h020, '0, '0);
    chk("t3_zero_mask", read_data, 32'h11BB33DD);
    chk("t3_valid1", read_valid, 2'b10);

    // 4. round-robin under continuous contention from reset
    do_reset();
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < N; c++)
        if (!p_act[c]) set_req(c, 1'b0, 1'b1, 'h010, '0, '0);
      step(g);
      chk("t4_rr", last_gnt, (it % 2 == 0) ? 2'b01 : 2'b10);
    end
    clear_reqs();
    access(0, 1'b0, 1'b1, 'h010, '0, '0);
    set_req(1, 1'b0, 1'b1, 'h010, '0, '0);
    step(g);
    chk("t4_solo1", last_gnt, 2'b10);
    set_req(1, 1'b0, 1'b1, 'h020, '0, '0);
    step(g);
    chk("t4_wrap1", last_gnt, 2'b10);

    // 5. read-first combined access, then reset right after a read grant
    access(0, 1'b1, 1'b0, 'h030, 32'h5, 4'hF);
    access(0, 1'b1, 1'b1, 'h030, 32'h9, 4'hF);
    chk("t5_read_first", read_data, 32'h5);
    access(1, 1'b0, 1'b1, 'h030, '0, '0);
    chk("t5_new", read_data, 32'h9);
    set_req(0, 1'b0, 1'b1, 'h030, '0, '0);
    step(g);
    rstn = 1'b0;
    clear_reqs();
    #1;
    chk("t5_rst_valid", read_valid, 0);
    chk("t5_rst_data", read_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rr_m = 0;
    rd_m = '0;
    @(posedge clk);
    #1;
    chk("t5_post_valid", read_valid, 0);
    chk("t5_post_gnt", gnt, 0);
    access(1, 1'b0, 1'b1, 'h030, '0, '0);
    chk("t5_preserved", read_data, 32'h9);

    // Randomized contention over a small address set including the top word
    foreach (picks[i]) access(i % N, 1'b1, 1'b0, picks[i], $urandom, 4'hF);
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!p_act[c] && $urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 2))
            0: set_req(c, 1'b1, 1'b0, picks[$urandom_range(0, 8)], $urandom, NB'($urandom_range(0, 15)));
            1: set_req(c, 1'b0, 1'b1, picks[$urandom_range(0, 8)], $urandom, NB'($urandom_range(0, 15)));
            default: set_req(c, 1'b1, 1'b1, picks[$urandom_range(0, 8)], $urandom, NB'($urandom_range(0, 15)));
          endcase
        end
      end
      step(g);
    end
    clear_reqs();
    step(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
